// File: rtl/adc_mic_reader.sv
// adc_mic_reader: serial-ADC front end for the microphone path.
// Generates chip select and serial clock for a framed ADC, starts one
// conversion per sample period, shifts in the data bits MSB first, flips
// the offset-binary result to two's complement, and hands each sample to
// the downstream consumer over a valid/ready handshake.
module adc_mic_reader #(
  parameter int ADC_CLOCK_DIV = 4,    // system clocks per adc_clk half period, >= 1
  parameter int FRAME_BITS    = 16,   // adc_clk rising edges per frame
  parameter int LEAD_BITS     = 4,    // leading zero bits dropped from each frame
  parameter int DATA_W        = 12,   // data bits kept after the lead bits
  parameter int SAMPLE_PERIOD = 1250  // system clocks between conversion starts
) (
  input  logic              clk,
  input  logic              reset,        // asynchronous, active low
  input  logic              enable,
  output logic              adc_clk,
  output logic              adc_cs,
  input  logic              adc_sd,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              busy
);

  localparam int PH_W  = $clog2(2 * ADC_CLOCK_DIV);
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [PH_W-1:0]   PH_HALF  = PH_W'(ADC_CLOCK_DIV - 1);
  localparam logic [PH_W-1:0]   PH_FULL  = PH_W'(2 * ADC_CLOCK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [DATA_W-1:0] SIGN_BIT = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    QUIET
  } state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  period_cnt;
  logic [PH_W-1:0]   ph, ph_d;        // cycle position within a phase or bit slot
  logic [BIT_W-1:0]  bit_cnt, bit_d;  // bit slot index within the frame
  logic              adc_clk_d;
  logic              adc_cs_d;
  logic              capture;         // this edge is an adc_clk rising edge
  logic              load;            // this edge ends the last slot of the frame
  logic              in_data;
  logic [DATA_W-1:0] raw;

  assign busy    = (state != IDLE);
  assign in_data = (int'(bit_cnt) >= LEAD_BITS) && (int'(bit_cnt) < LEAD_BITS + DATA_W);

  // Free-running period counter; it keeps counting while disabled so the
  // start grid stays fixed relative to reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
    end else if (period_cnt == CNT_LAST) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and next-output logic for the conversion sequence.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    ph_d       = ph + 1'b1;
    bit_d      = bit_cnt;
    adc_clk_d  = adc_clk;
    capture    = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        ph_d      = '0;
        adc_clk_d = 1'b1;
        // A wrap seen outside IDLE is simply missed, so starts never overlap.
        if (period_cnt == '0 && enable) begin
          next_state = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (ph == PH_HALF) begin
          next_state = SHIFT;
          ph_d       = '0;
          bit_d      = '0;
          adc_clk_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (ph == PH_HALF) begin
          adc_clk_d = 1'b1;
          capture   = 1'b1;
        end else if (ph == PH_FULL) begin
          ph_d = '0;
          if (bit_cnt == BIT_LAST) begin
            next_state = QUIET;
            load       = 1'b1;
          end else begin
            bit_d     = bit_cnt + 1'b1;
            adc_clk_d = 1'b0;
          end
        end
      end
      QUIET: begin
        if (ph == PH_HALF) begin
          next_state = IDLE;
          ph_d       = '0;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    // Chip select is low exactly while setting up or shifting.
    adc_cs_d = (next_state == IDLE) || (next_state == QUIET);
  end

  // Serial interface registers: adc_cs/adc_clk come straight from flops so
  // the pins never glitch; raw collects the data bits MSB first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph      <= '0;
      bit_cnt <= '0;
      adc_clk <= 1'b1;
      adc_cs  <= 1'b1;
      raw     <= '0;
    end else begin
      ph      <= ph_d;
      bit_cnt <= bit_d;
      adc_clk <= adc_clk_d;
      adc_cs  <= adc_cs_d;
      if (capture && in_data) begin
        raw <= {raw[DATA_W-2:0], adc_sd};
      end
    end
  end

  // Output holding register and handshake; a new load beats a same-edge
  // consume and flags overrun when it displaces an unread sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      sample       <= raw ^ SIGN_BIT;
      sample_valid <= 1'b1;
      overrun      <= sample_valid && !sample_ready;
    end else begin
      overrun <= 1'b0;
      if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_mic_reader.sv
// Testbench for adc_mic_reader: directed frames from a behavioural ADC
// model, checked against hand-computed samples and frame timing.
module tb_adc_mic_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        adc_clk;
  logic        adc_cs;
  logic        adc_sd;
  logic [11:0] sample;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        busy;

  // Second instance with a short period to exercise skipped starts.
  logic        p_enable;
  logic        p_clk;
  logic        p_cs;
  logic        p_sd;
  logic [11:0] p_sample;
  logic        p_valid;
  logic        p_ready;
  logic        p_overrun;
  logic        p_busy;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          ov_cnt   = 0;
  logic [15:0] adc_frame = 16'h0000;
  int          slot     = 0;

  adc_mic_reader dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .adc_clk      (adc_clk),
    .adc_cs       (adc_cs),
    .adc_sd       (adc_sd),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  adc_mic_reader #(.SAMPLE_PERIOD(100)) dut_p100 (
    .clk          (clk),
    .reset        (reset),
    .enable       (p_enable),
    .adc_clk      (p_clk),
    .adc_cs       (p_cs),
    .adc_sd       (p_sd),
    .sample       (p_sample),
    .sample_valid (p_valid),
    .sample_ready (p_ready),
    .overrun      (p_overrun),
    .busy         (p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp chip-select edges.
  always @(posedge clk) cyc <= cyc + 1;

  // Overrun pulse counter, sampled mid-cycle.
  always @(negedge clk) if (overrun === 1'b1) ov_cnt = ov_cnt + 1;

  // ADC model: new bit presented on each adc_clk falling edge, MSB first.
  always @(negedge adc_cs) slot = 0;
  always @(negedge adc_clk) begin
    if (adc_cs === 1'b0) begin
      if (slot < 16) adc_sd = adc_frame[4'(15 - slot)];
      slot = slot + 1;
    end
  end

  // Wait for a chip-select falling edge on the selected instance.
  task automatic wait_cs_fall(input bit sel, output bit ok, output int stamp);
    logic prev;
    logic cur;
    ok    = 1'b0;
    stamp = -1;
    prev  = sel ? p_cs : adc_cs;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      cur = sel ? p_cs : adc_cs;
      if (prev === 1'b1 && cur === 1'b0) begin
        ok    = 1'b1;
        stamp = cyc;
      end
      prev = cur;
    end
  endtask

  // Run one conversion of the main instance; enable drops right after start.
  task automatic run_frame(input logic [15:0] frame, output int vlat, output int len,
                           output int rises, output bit ok);
    logic prev_clk;
    int   stamp;
    adc_frame = frame;
    enable    = 1'b1;
    vlat      = -1;
    len       = -1;
    rises     = 0;
    wait_cs_fall(1'b0, ok, stamp);
    enable = 1'b0;
    if (ok) begin
      prev_clk = adc_clk;
      for (int n = 1; n <= 400 && len < 0; n++) begin
        @(negedge clk);
        if (prev_clk === 1'b0 && adc_clk === 1'b1) rises++;
        prev_clk = adc_clk;
        if (vlat < 0 && sample_valid === 1'b1) vlat = n;
        if (busy === 1'b0) len = n;
      end
      if (len < 0) ok = 1'b0;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    int rises;
    logic prev_clk;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (adc_cs !== 1'b1) begin failures++; $display("FAIL reset_cs: got %b expected 1", adc_cs); end
    checks++;
    if (adc_clk !== 1'b1) begin failures++; $display("FAIL reset_clk: got %b expected 1", adc_clk); end
    checks++;
    if (sample !== 12'h000) begin failures++; $display("FAIL reset_sample: got %h expected 000", sample); end
    checks++;
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_ov_busy: got %b%b expected 00", overrun, busy);
    end
    reset    = 1'b1;
    bad      = 1'b0;
    rises    = 0;
    prev_clk = adc_clk;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (adc_cs !== 1'b1 || adc_clk !== 1'b1 || sample_valid !== 1'b0) bad = 1'b1;
      if (prev_clk === 1'b0 && adc_clk === 1'b1) rises++;
      prev_clk = adc_clk;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL idle_outputs: got activity expected idle pins"); end
    checks++;
    if (rises != 0) begin failures++; $display("FAIL idle_clk_edges: got %0d expected 0", rises); end
  endtask

  task automatic test_single();
    int vlat, len, rises;
    bit ok;
    run_frame(16'h0801, vlat, len, rises, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got no frame expected one"); end
    checks++;
    if (rises != 16) begin failures++; $display("FAIL single_rises: got %0d expected 16", rises); end
    checks++;
    if (vlat != 132) begin failures++; $display("FAIL single_valid_latency: got %0d expected 132", vlat); end
    checks++;
    if (len != 136) begin failures++; $display("FAIL single_length: got %0d expected 136", len); end
    checks++;
    if (sample !== 12'h001) begin failures++; $display("FAIL single_sample: got %h expected 001", sample); end
    consume();
    checks++;
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL single_consume: got %b expected 0", sample_valid); end
  endtask

  task automatic test_sign();
    logic [15:0] frames [3] = '{16'h0000, 16'h07FF, 16'h0FFF};
    logic [11:0] exp    [3] = '{12'h800, 12'hFFF, 12'h7FF};
    int vlat, len, rises;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      run_frame(frames[k], vlat, len, rises, ok);
      checks++;
      if (!ok || sample !== exp[k]) begin
        failures++;
        $display("FAIL sign_%0d: got %h (ok=%0b) expected %h", k, sample, ok, exp[k]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int vlat, len, rises;
    bit ok_a, ok_b;
    sample_ready = 1'b0;
    ov_cnt       = 0;
    run_frame(16'h0123, vlat, len, rises, ok_a);
    run_frame(16'h0456, vlat, len, rises, ok_b);
    checks++;
    if (!ok_a || !ok_b) begin failures++; $display("FAIL bp_timeout: got ok=%0b%0b expected 11", ok_a, ok_b); end
    checks++;
    if (ov_cnt != 1) begin failures++; $display("FAIL bp_overrun: got %0d expected 1", ov_cnt); end
    checks++;
    if (sample !== 12'hC56 || sample_valid !== 1'b1) begin
      failures++; $display("FAIL bp_sample: got %h v=%b expected c56 v=1", sample, sample_valid);
    end
    consume();
    checks++;
    if (sample_valid !== 1'b0) begin failures++; $display("FAIL bp_clear: got %b expected 0", sample_valid); end
  endtask

  task automatic test_period();
    int t1, t2;
    bit ok1, ok2;
    enable = 1'b1;
    wait_cs_fall(1'b0, ok1, t1);
    wait_cs_fall(1'b0, ok2, t2);
    enable = 1'b0;
    checks++;
    if (!ok1 || !ok2 || t2 - t1 != 1250) begin
      failures++; $display("FAIL period_1250: got %0d expected 1250", t2 - t1);
    end
    while (busy !== 1'b0) @(negedge clk);
    consume();
    p_enable = 1'b1;
    wait_cs_fall(1'b1, ok1, t1);
    wait_cs_fall(1'b1, ok2, t2);
    p_enable = 1'b0;
    checks++;
    if (!ok1 || !ok2 || t2 - t1 != 200) begin
      failures++; $display("FAIL period_100: got %0d expected 200", t2 - t1);
    end
  endtask

  task automatic test_mid_events();
    int stamp, t;
    bit ok, fell, done;
    // Drop enable inside bit 5: frame must still complete and deliver.
    adc_frame = 16'h0ABC;
    enable    = 1'b1;
    wait_cs_fall(1'b0, ok, stamp);
    repeat (46) @(negedge clk);
    enable = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!ok || !done || sample_valid !== 1'b1 || sample !== 12'h2BC) begin
      failures++; $display("FAIL en_drop_sample: got %h v=%b expected 2bc v=1", sample, sample_valid);
    end
    wait_cs_fall(1'b0, fell, t);
    checks++;
    if (fell) begin failures++; $display("FAIL en_drop_no_start: got start expected none"); end
    consume();
    // Reset inside bit 8: pins go idle at once and nothing is delivered.
    adc_frame = 16'h0FFF;
    enable    = 1'b1;
    wait_cs_fall(1'b0, ok, stamp);
    repeat (70) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (!ok || adc_cs !== 1'b1 || adc_clk !== 1'b1) begin
      failures++; $display("FAIL async_reset_pins: got cs=%b clk=%b expected 1 1", adc_cs, adc_clk);
    end
    checks++;
    if (sample_valid !== 1'b0 || sample !== 12'h000 || busy !== 1'b0) begin
      failures++; $display("FAIL async_reset_data: got %h v=%b b=%b expected 000 0 0", sample, sample_valid, busy);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (adc_cs !== 1'b0) begin failures++; $display("FAIL restart_at_zero: got cs=%b expected 0", adc_cs); end
    enable = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || sample !== 12'h7FF) begin
      failures++; $display("FAIL restart_sample: got %h expected 7ff", sample);
    end
    consume();
  endtask

  initial begin
    reset        = 1'b0;
    enable       = 1'b0;
    sample_ready = 1'b0;
    adc_sd       = 1'b0;
    p_enable     = 1'b0;
    p_sd         = 1'b0;
    p_ready      = 1'b1;
    test_reset();
    test_single();
    test_sign();
    test_back_to_back();
    test_period();
    test_mid_events();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
